// File: rtl/jk_ff_arbiter_if.sv
// jk_ff_arbiter_if: requester/flip-flop bundle shared by the arbiter and its users
//   iReq0/iReq1   request from requester 0/1, held until the matching ack
//   iJK0/iJK1     {J,K} command from requester 0/1
//   oGnt0/oGnt1   level: requester owns the flip-flop
//   oAck0/oAck1   one-cycle pulse: requester's command was applied
//   oTick         one-cycle pulse every DIV system cycles
//   oQ/oQ_bar     flip-flop state and its complement
//   oCount        applied-command counter, wraps 255 -> 0
interface jk_ff_arbiter_if;
    logic       iReq0;
    logic [1:0] iJK0;
    logic       iReq1;
    logic [1:0] iJK1;
    logic       oGnt0;
    logic       oGnt1;
    logic       oAck0;
    logic       oAck1;
    logic       oTick;
    logic       oQ;
    logic       oQ_bar;
    logic [7:0] oCount;

    modport master (
        output iReq0, iJK0, iReq1, iJK1,
        input  oGnt0, oGnt1, oAck0, oAck1, oTick, oQ, oQ_bar, oCount
    );

    modport slave (
        input  iReq0, iJK0, iReq1, iJK1,
        output oGnt0, oGnt1, oAck0, oAck1, oTick, oQ, oQ_bar, oCount
    );
endinterface

// File: rtl/jk_ff_arbiter.sv
// jk_ff_arbiter: round-robin sharing of one divided-clock JK flip-flop between two requesters
//   iClk    system clock, rising edge
//   iReset  asynchronous active-low reset
//   bus     jk_ff_arbiter_if.slave: requests/commands in; grants, acks, tick, Q, count out
//   DIV     system cycles per divided tick (2..65535)
module jk_ff_arbiter #(
    parameter int DIV = 10
) (
    input  logic                  iClk,
    input  logic                  iReset,
    jk_ff_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, GRANTED, ACK} state_t;

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
    localparam logic [15:0] CNT_PRE  = 16'(DIV - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_tick;
    logic        r_pri;
    logic        w_pri_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic [1:0]  r_jk;
    logic [1:0]  w_jk_nxt;
    logic        r_q;
    logic        w_q_nxt;
    logic        w_apply;
    logic [7:0]  r_count;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_ack0;
    logic        r_ack1;

    // Free-running divider; the tick flag is registered one cycle ahead so it
    // is high exactly while cnt == DIV-1.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 16'd1;
            r_tick <= (r_cnt == CNT_PRE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_jk_nxt    = r_jk;
        w_pri_nxt   = r_pri;
        w_apply     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.iReq0 || bus.iReq1) begin
                    // Contention goes to the round-robin pointer, otherwise to the lone requester.
                    w_owner_nxt = (bus.iReq0 && bus.iReq1) ? r_pri : bus.iReq1;
                    w_jk_nxt    = w_owner_nxt ? bus.iJK1 : bus.iJK0;
                    w_state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                if (r_tick) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_pri_nxt   = ~r_owner;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_q_nxt = !w_apply          ? r_q   :
                  (r_jk == 2'b11)   ? ~r_q  :
                  (r_jk == 2'b10)   ? 1'b1  :
                  (r_jk == 2'b01)   ? 1'b0  : r_q;
    end

    // Grant/ack outputs are registered from the next-state decode so they line
    // up with the state they describe.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_jk    <= 2'b00;
            r_pri   <= 1'b0;
            r_q     <= 1'b0;
            r_count <= 8'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_jk    <= w_jk_nxt;
            r_pri   <= w_pri_nxt;
            r_q     <= w_q_nxt;
            r_count <= w_apply ? r_count + 8'd1 : r_count;
            r_gnt0  <= (w_state_nxt != IDLE) && !w_owner_nxt;
            r_gnt1  <= (w_state_nxt != IDLE) &&  w_owner_nxt;
            r_ack0  <= (w_state_nxt == ACK)  && !w_owner_nxt;
            r_ack1  <= (w_state_nxt == ACK)  &&  w_owner_nxt;
        end
    end

    assign bus.oGnt0  = r_gnt0;
    assign bus.oGnt1  = r_gnt1;
    assign bus.oAck0  = r_ack0;
    assign bus.oAck1  = r_ack1;
    assign bus.oTick  = r_tick;
    assign bus.oQ     = r_q;
    assign bus.oQ_bar = ~r_q;
    assign bus.oCount = r_count;
endmodule

// File: doc/jk_ff_arbiter.md
# jk_ff_arbiter

Shares one divided-clock JK flip-flop between two requesters. Each requester presents a JK command with a request/acknowledge handshake. A round-robin arbiter grants one requester at a time, and the granted command is applied to the flip-flop state on the next divided-clock tick. The block sits between requester logic and the JK storage element, replacing direct J/K drive when more than one source must update the same flip-flop.

## Interface
- DIV, 10, system clock cycles per divided tick; legal range 2..65535
- iClk  in  1  system clock, rising edge
- iReset  in  1  asynchronous, active-low reset
- iReq0  in  1  request from requester 0; hold until oAck0
- iJK0  in  2  command from requester 0, {J,K}
- iReq1  in  1  request from requester 1; hold until oAck1
- iJK1  in  2  command from requester 1, {J,K}
- oGnt0  out  1  requester 0 owns the flip-flop (level)
- oGnt1  out  1  requester 1 owns the flip-flop (level)
- oAck0  out  1  one-cycle pulse: requester 0 command applied
- oAck1  out  1  one-cycle pulse: requester 1 command applied
- oTick  out  1  one-cycle pulse every DIV cycles (divided clock)
- oQ  out  1  flip-flop state
- oQ_bar  out  1  always ~oQ
- oCount  out  8  number of commands applied; wraps 255 -> 0

## Operation
- **Tick counter:** cnt counts 0..DIV-1 and wraps. oTick = (cnt == DIV-1). The counter free-runs regardless of FSM state.
- **JK rule at apply:**
  - 00: hold
  - 01: Q <= 0
  - 10: Q <= 1
  - 11: Q <= ~Q
- **Round-robin pointer** pri ∈ {0,1}. In IDLE:
  - If only one request is high, that requester wins.
  - If both are high, requester pri wins.
- **FSM states:**
  - IDLE: if any iReq is high, latch winner index and its iJK (snapshot), then -> GRANTED. Otherwise stay.
  - GRANTED: assert oGnt[owner]. When oTick = 1 this cycle: apply the latched command to Q, increment oCount, -> ACK. Otherwise stay.
  - ACK: assert oGnt[owner] and oAck[owner]. Set pri <= ~owner, then -> IDLE.
- **Snapshot rule:** the command is latched at grant. Changes to iJK or iReq after grant are ignored.
- **Request dropped while GRANTED:** the command is still applied and acknowledged.
- **Request still high in the IDLE cycle after ACK:** treated as a new request, subject to round-robin priority.
- **Tick coincident with the IDLE arbitration cycle:** not used. Only ticks seen while in GRANTED apply a command.
- oGnt0 and oGnt1 are never high simultaneously; likewise oAck0 and oAck1.
- oCount increments only on apply, i.e. the GRANTED -> ACK transition.

## Timing
- **Reset values** (iReset low, immediate and asynchronous):
  - cnt = 0, state = IDLE, pri = 0
  - oQ = 0, oQ_bar = 1, oCount = 0
  - oGnt0 = oGnt1 = oAck0 = oAck1 = oTick = 0
- **Reset release:** the first rising edge with iReset high is cycle 0 (cnt = 0). oTick is first high in cycle DIV-1.
- **Reset mid-operation:** any pending grant is discarded without an ack, and Q is forced to 0.
- **Grant timing:** iReq sampled high in IDLE at cycle t gives oGnt high from cycle t+1.
- **Apply and ack:** on the first cycle u ≥ t+1 with oTick = 1:
  - Q and oCount update at the end of cycle u.
  - oAck is high in cycle u+1, with the new oQ visible in that cycle.
  - oGnt drops in cycle u+2.
- **Latency:** from request to oAck, 2..DIV+1 cycles.
- **Throughput:** at most one command per tick, i.e. per DIV cycles.
- All outputs are registered except oQ_bar, which is the inverter of registered Q.

## Test plan
1. **Reset and divider.** DIV = 4, hold iReset low for 3 cycles, then release. Required: oQ = 0, oQ_bar = 1, oCount = 0; oTick pulses in cycles 3, 7, 11; no grants.
2. **Single set and toggle.** iReq0 = 1, iJK0 = 10 in cycle 0. Required: oGnt0 high from cycle 1; Q = 1 and oAck0 high in cycle 4; oCount = 1. Then issue iJK0 = 11. Required: Q = 0 on the next ack; oCount = 2.
3. **Contention.** Both requests high in cycle 0, with iJK0 = 10 and iJK1 = 01. Required:
   - Requester 0 is served first (pri = 0): Q = 1 and oAck0 in cycle 4.
   - Requester 1 is served next: oGnt1 from cycle 6; Q = 0 and oAck1 in cycle 8.
   - oGnt0 and oGnt1 never overlap.
4. **Fairness.** Both requests held permanently, each set to 11. Required: acks alternate 0,1,0,1; Q toggles on every ack; oCount = 4 after four acks.
5. **Snapshot.** Requester 1 is granted with 10; change iJK1 to 01 and drop iReq1 while in GRANTED. Required: Q becomes 1 and oAck1 still pulses.
6. **Reset mid-grant and wrap.**
   - Assert reset during GRANTED with Q = 1. Required: Q = 0 and oGnt = 0 immediately; no ack.
   - Apply 256 commands. Required: oCount wraps to 0.
